microondas_sequenciador: RTL and testbench

Cooking-session sequencer for the microwave controller. It owns the programmed time (mm:ss), the run/pause/door/done state machine and the magnetron on/off duty cycle for the selected power level. It sits between the debounced front-panel inputs and the 7-segment display and RGB driver blocks, which consume its time, state and power outputs.

---
 rtl/microondas_pkg.sv | 80 ++++++++
 rtl/divisor_tick.sv | 32 +++
 rtl/microondas_sequenciador.sv | 143 ++++++++++++++
 tb/tb_microondas_sequenciador.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
// Shared types, codes and time-arithmetic helpers for the microwave cooking sequencer.
// Times are mm:ss held as a packed struct so editing and countdown share one representation.
package microondas_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COOK   = 3'd1,
    PAUSED = 3'd2,
    DONE   = 3'd3
  } estado_t;

  localparam logic [1:0] PASSO_NENHUM = 2'b00;
  localparam logic [1:0] PASSO_1S     = 2'b01;
  localparam logic [1:0] PASSO_10S    = 2'b10;
  localparam logic [1:0] PASSO_60S    = 2'b11;

  localparam logic [1:0] POT_BAIXA = 2'b00;
  localparam logic [1:0] POT_MEDIA = 2'b10;
  localparam logic [1:0] POT_ALTA  = 2'b11;

  localparam int MAX_MIN = 99;
  localparam int MAX_SEG = 59;

  typedef struct packed {
    logic [6:0] min;
    logic [5:0] seg;
  } tempo_t;

  // Adds one step; anything past 99:59 saturates there.
  function automatic tempo_t tempo_soma(input tempo_t t, input logic [1:0] passo);
    tempo_t     r;
    logic [7:0] min_n;
    logic [6:0] seg_n;
    min_n = {1'b0, t.min};
    seg_n = {1'b0, t.seg};
    case (passo)
      PASSO_1S:  seg_n = seg_n + 7'd1;
      PASSO_10S: seg_n = seg_n + 7'd10;
      PASSO_60S: min_n = min_n + 8'd1;
      default:   ;
    endcase
    if (seg_n >= 7'd60) begin
      seg_n = seg_n - 7'd60;
      min_n = min_n + 8'd1;
    end
    if (min_n > 8'(MAX_MIN)) begin
      r.min = 7'(MAX_MIN);
      r.seg = 6'(MAX_SEG);
    end else begin
      r.min = min_n[6:0];
      r.seg = seg_n[5:0];
    end
    return r;
  endfunction

  // Subtracts one step, borrowing a minute when needed; underflow saturates at 00:00.
  function automatic tempo_t tempo_subtrai(input tempo_t t, input logic [1:0] passo);
    tempo_t     r;
    logic [5:0] dec;
    r = t;
    case (passo)
      PASSO_1S:  dec = 6'd1;
      PASSO_10S: dec = 6'd10;
      default:   dec = 6'd0;
    endcase
    if (passo == PASSO_60S) begin
      if (t.min == 7'd0) r = '0;
      else               r.min = t.min - 7'd1;
    end else if (t.seg >= dec) begin
      r.seg = t.seg - dec;
    end else if (t.min != 7'd0) begin
      r.min = t.min - 7'd1;
      r.seg = t.seg + 6'd60 - dec;
    end else begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// One-second tick generator: pulses once every TICK_DIV enabled cycles.
// The count freezes while enable is low so a paused cook resumes mid-second.
module divisor_tick #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] ULTIMO = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = enable & (cnt_q == ULTIMO);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/microondas_sequenciador.sv
// Cooking-session sequencer: programmed mm:ss, IDLE/COOK/PAUSED/DONE control and
// magnetron duty cycle per power level; feeds the display and lamp drivers.
module microondas_sequenciador
  import microondas_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int FIM_SEG  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       porta,
  input  logic       mais,
  input  logic       menos,
  input  logic [1:0] passo,
  input  logic [1:0] potencia,
  output logic [6:0] tempo_min,
  output logic [5:0] tempo_seg,
  output logic       magnetron,
  output logic       luz,
  output logic       fim,
  output logic [2:0] estado
);

  localparam int FW = (FIM_SEG > 1) ? $clog2(FIM_SEG) : 1;

  estado_t       state_q, state_d;
  tempo_t        tempo_q, tempo_d;
  logic [1:0]    fase_q, fase_d;
  logic [FW-1:0] fim_cnt_q, fim_cnt_d;
  logic [4:0]    btn_q, btn, ev;
  logic          start_ev, stop_ev, pause_ev, mais_ev, menos_ev;
  logic          tick, en_div, clear_div, pode_iniciar, fase_ok;
  tempo_t        editado, decrementado;

  assign btn = {start, stop, pause, mais, menos};
  assign ev  = btn & ~btn_q;
  assign {start_ev, stop_ev, pause_ev, mais_ev, menos_ev} = ev;

  assign pode_iniciar = ~porta & (tempo_q != '0);
  assign decrementado = tempo_subtrai(tempo_q, PASSO_1S);
  assign editado      = mais_ev  ? tempo_soma(tempo_q, passo)    :
                        menos_ev ? tempo_subtrai(tempo_q, passo) : tempo_q;

  // Higher-priority exits suppress counting so the held count survives a pause.
  assign en_div = ((state_q == COOK) & ~stop_ev & ~porta & ~pause_ev) | (state_q == DONE);

  divisor_tick #(.TICK_DIV(TICK_DIV)) u_divisor (
    .clock  (clock),
    .reset  (reset),
    .enable (en_div),
    .clear  (clear_div),
    .tick   (tick)
  );

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d   = state_q;
    tempo_d   = tempo_q;
    fase_d    = fase_q;
    fim_cnt_d = fim_cnt_q;
    clear_div = 1'b0;
    case (state_q)
      IDLE, PAUSED: begin
        if (stop_ev) begin
          state_d = IDLE;
          tempo_d = '0;
        end else if (start_ev) begin
          if (pode_iniciar) begin
            state_d = COOK;
            if (state_q == IDLE) begin
              clear_div = 1'b1;
              fase_d    = '0;
            end
          end
        end else begin
          tempo_d = editado;
        end
      end
      COOK: begin
        if (stop_ev) begin
          state_d = IDLE;
          tempo_d = '0;
        end else if (porta || pause_ev) begin
          state_d = PAUSED;
        end else if (tick) begin
          tempo_d = decrementado;
          fase_d  = fase_q + 2'd1;
          if (decrementado == '0) begin
            state_d   = DONE;
            fim_cnt_d = '0;
          end
        end
      end
      DONE: begin
        if (stop_ev) begin
          state_d = IDLE;
          tempo_d = '0;
        end else if (porta || start_ev || pause_ev) begin
          state_d = IDLE;
        end else if (tick) begin
          if (fim_cnt_q == FW'(FIM_SEG - 1)) state_d = IDLE;
          else                               fim_cnt_d = fim_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tempo_q   <= '0;
      fase_q    <= '0;
      fim_cnt_q <= '0;
      btn_q     <= '0;
    end else begin
      state_q   <= state_d;
      tempo_q   <= tempo_d;
      fase_q    <= fase_d;
      fim_cnt_q <= fim_cnt_d;
      btn_q     <= btn;
    end
  end

  always_comb begin
    case (potencia)
      POT_ALTA:  fase_ok = 1'b1;
      POT_MEDIA: fase_ok = ~fase_q[0];
      default:   fase_ok = (fase_q == 2'd0);
    endcase
  end

  assign magnetron = (state_q == COOK) & ~porta & fase_ok;
  assign luz       = porta | (state_q == COOK);
  assign fim       = (state_q == DONE);
  assign estado    = state_q;
  assign tempo_min = tempo_q.min;
  assign tempo_seg = tempo_q.seg;

endmodule

// File: tb/tb_microondas_sequenciador.sv
// Directed bench for the microwave sequencer with TICK_DIV = 4 and FIM_SEG = 3.
// Inputs change on the falling edge; outputs are checked on falling edges.
module tb_microondas_sequenciador;

  localparam int TICK_DIV = 4;
  localparam int FIM_SEG  = 3;
  localparam int B_START  = 4;
  localparam int B_STOP   = 3;
  localparam int B_PAUSE  = 2;
  localparam int B_MAIS   = 1;
  localparam int B_MENOS  = 0;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] botoes;
  logic       porta;
  logic [1:0] passo, potencia;
  logic [6:0] tempo_min;
  logic [5:0] tempo_seg;
  logic       magnetron, luz, fim;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;
  int n_on;

  always #5 clock = ~clock;

  microondas_sequenciador #(.TICK_DIV(TICK_DIV), .FIM_SEG(FIM_SEG)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (botoes[B_START]),
    .stop      (botoes[B_STOP]),
    .pause     (botoes[B_PAUSE]),
    .porta     (porta),
    .mais      (botoes[B_MAIS]),
    .menos     (botoes[B_MENOS]),
    .passo     (passo),
    .potencia  (potencia),
    .tempo_min (tempo_min),
    .tempo_seg (tempo_seg),
    .magnetron (magnetron),
    .luz       (luz),
    .fim       (fim),
    .estado    (estado)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Time shown as mm*100+ss so 01:50 reads as 150.
  function automatic logic [31:0] tempo_atual();
    return 32'(tempo_min) * 32'd100 + 32'(tempo_seg);
  endfunction

  task automatic espera(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic aperta(input int idx, input int hold);
    botoes[idx] = 1'b1;
    espera(hold);
    botoes[idx] = 1'b0;
    espera(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    botoes   = 5'b0;
    botoes[B_STOP] = 1'b1;
    porta    = 1'b0;
    passo    = 2'b01;
    potencia = 2'b11;
    espera(3);
    check("reset_estado", 32'(estado), 32'd0);
    check("reset_tempo", tempo_atual(), 32'd0);
    check("reset_outs", {29'd0, magnetron, luz, fim}, 32'd0);
    reset = 1'b1;
    espera(3);
    check("stop_held_estado", 32'(estado), 32'd0);
    check("stop_held_tempo", tempo_atual(), 32'd0);
    botoes[B_STOP] = 1'b0;
    espera(2);

    // One action per press, appearing one cycle after the rise.
    botoes[B_MAIS] = 1'b1;
    espera(1);
    check("mais_first_cycle", tempo_atual(), 32'd1);
    espera(14);
    check("mais_held_once", tempo_atual(), 32'd1);
    botoes[B_MAIS] = 1'b0;
    espera(2);
    aperta(B_MAIS, 15);
    aperta(B_MAIS, 15);
    check("mais_x3", tempo_atual(), 32'd3);

    aperta(B_STOP, 2);
    check("stop_clear", tempo_atual(), 32'd0);
    passo = 2'b11;
    aperta(B_MAIS, 2);
    aperta(B_MAIS, 2);
    check("mais_60s_x2", tempo_atual(), 32'd200);
    passo = 2'b10;
    aperta(B_MENOS, 2);
    check("menos_borrow", tempo_atual(), 32'd150);

    aperta(B_STOP, 2);
    passo = 2'b01;
    for (int i = 0; i < 5; i++) aperta(B_MAIS, 2);
    check("mais_to_5", tempo_atual(), 32'd5);
    passo = 2'b10;
    aperta(B_MENOS, 2);
    check("menos_sat_zero", tempo_atual(), 32'd0);

    passo = 2'b11;
    for (int i = 0; i < 99; i++) aperta(B_MAIS, 1);
    check("mais_99min", tempo_atual(), 32'd9900);
    passo = 2'b10;
    aperta(B_MENOS, 2);
    check("menos_98_50", tempo_atual(), 32'd9850);
    passo = 2'b01;
    for (int i = 0; i < 5; i++) aperta(B_MAIS, 2);
    passo = 2'b11;
    aperta(B_MAIS, 2);
    check("mais_99_55", tempo_atual(), 32'd9955);
    passo = 2'b10;
    aperta(B_MAIS, 2);
    check("mais_sat_99_59", tempo_atual(), 32'd9959);
    aperta(B_MAIS, 2);
    check("mais_sat_hold", tempo_atual(), 32'd9959);
    passo = 2'b00;
    aperta(B_MENOS, 2);
    check("passo_none", tempo_atual(), 32'd9959);
    passo = 2'b01;
    aperta(B_MENOS, 2);
    check("menos_1s", tempo_atual(), 32'd9958);

    // Full cook from 00:03 at high power.
    aperta(B_STOP, 2);
    for (int i = 0; i < 3; i++) aperta(B_MAIS, 2);
    check("cook_setup", tempo_atual(), 32'd3);
    botoes[B_START] = 1'b1;
    espera(1);
    check("cook_entry_estado", 32'(estado), 32'd1);
    check("cook_entry_mag", 32'(magnetron), 32'd1);
    check("cook_entry_luz", 32'(luz), 32'd1);
    botoes[B_START] = 1'b0;
    espera(3);
    check("cook_before_tick", tempo_atual(), 32'd3);
    espera(1);
    check("cook_first_tick", tempo_atual(), 32'd2);
    espera(7);
    check("cook_n12_estado", 32'(estado), 32'd1);
    check("cook_n12_tempo", tempo_atual(), 32'd1);
    espera(1);
    check("done_estado", 32'(estado), 32'd3);
    check("done_fim", 32'(fim), 32'd1);
    check("done_mag", 32'(magnetron), 32'd0);
    check("done_tempo", tempo_atual(), 32'd0);
    espera(11);
    check("done_last_cycle", {30'd0, fim, estado == 3'd3}, 32'd3);
    espera(1);
    check("done_to_idle", 32'(estado), 32'd0);
    check("done_fim_off", 32'(fim), 32'd0);

    // Door open mid-cook, then resume with held tick count.
    passo = 2'b10;
    aperta(B_MAIS, 2);
    check("pause_setup", tempo_atual(), 32'd10);
    botoes[B_START] = 1'b1;
    espera(1);
    botoes[B_START] = 1'b0;
    espera(5);
    check("pause_run_09", tempo_atual(), 32'd9);
    porta = 1'b1;
    #1;
    check("porta_mag_comb", 32'(magnetron), 32'd0);
    check("porta_luz_comb", 32'(luz), 32'd1);
    espera(1);
    check("porta_paused", 32'(estado), 32'd2);
    espera(8);
    check("paused_frozen", tempo_atual(), 32'd9);
    aperta(B_START, 1);
    check("start_porta_ignored", 32'(estado), 32'd2);
    porta = 1'b0;
    espera(1);
    check("paused_luz_off", 32'(luz), 32'd0);
    botoes[B_START] = 1'b1;
    espera(1);
    check("resume_estado", 32'(estado), 32'd1);
    botoes[B_START] = 1'b0;
    espera(2);
    check("resume_before_tick", tempo_atual(), 32'd9);
    espera(1);
    check("resume_held_count", tempo_atual(), 32'd8);
    aperta(B_STOP, 2);
    check("stop_cook", {25'd0, estado, 4'd0} + tempo_atual(), 32'd0);

    // Low power: one phase in four.
    aperta(B_MAIS, 2);
    passo = 2'b01;
    aperta(B_MENOS, 2);
    aperta(B_MENOS, 2);
    check("low_setup", tempo_atual(), 32'd8);
    potencia = 2'b00;
    botoes[B_START] = 1'b1;
    n_on = 0;
    for (int i = 0; i < 16; i++) begin
      espera(1);
      if (magnetron) n_on++;
    end
    check("low_duty", 32'(n_on), 32'd4);
    espera(1);
    check("low_phase0_again", 32'(magnetron), 32'd1);
    botoes[B_START] = 1'b0;
    aperta(B_STOP, 2);

    // Medium power: two phases in four.
    passo = 2'b10;
    aperta(B_MAIS, 2);
    passo = 2'b01;
    aperta(B_MENOS, 2);
    aperta(B_MENOS, 2);
    potencia = 2'b10;
    botoes[B_START] = 1'b1;
    n_on = 0;
    for (int i = 0; i < 16; i++) begin
      espera(1);
      if (magnetron) n_on++;
    end
    check("med_duty", 32'(n_on), 32'd8);
    botoes[B_START] = 1'b0;
    aperta(B_STOP, 2);

    // Simultaneous stop and start while paused; start at 00:00 ignored.
    passo = 2'b10;
    aperta(B_MAIS, 2);
    aperta(B_START, 2);
    check("sim_cook", 32'(estado), 32'd1);
    aperta(B_PAUSE, 2);
    check("sim_paused", 32'(estado), 32'd2);
    check("sim_paused_tempo", tempo_atual(), 32'd10);
    botoes[B_STOP]  = 1'b1;
    botoes[B_START] = 1'b1;
    espera(1);
    check("stop_beats_start", 32'(estado), 32'd0);
    check("stop_beats_start_t", tempo_atual(), 32'd0);
    botoes[B_STOP]  = 1'b0;
    botoes[B_START] = 1'b0;
    espera(2);
    aperta(B_START, 2);
    check("start_zero_ignored", 32'(estado), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
